mc_core_ctrl: RTL and testbench

//  Multi-cycle successor to the single-cycle core control. Owns PC, IR and the RV32I decode.

---
 rtl/mc_core_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mc_core_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_core_ctrl
// Purpose  : Multi-cycle RV32I core control. Owns PC, IR and instruction
//            decode, and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK against
//            ready-handshaked instruction and data memories. Raises a sticky
//            fault on illegal opcode, misaligned control transfer or memory
//            timeout.
// Ports    : clk, reset          - clock / async active-high reset
//            imem_req/addr/ready/rdata - instruction fetch handshake
//            dmem_req/we/ready   - data access handshake
//            br_taken, pc_target - datapath branch result and PC+imm target
//            pc, instr           - architectural PC and instruction register
//            reg_wen, alu_sel, bsel, wb_sel, imm_sel, branch_type
//                                - datapath control
//            retire, fault, state - status / debug
// Revision : 1.0 - initial release
// ============================================================================
module mc_core_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            reg_wen,
  output logic [3:0]      alu_sel,
  output logic            bsel,
  output logic [1:0]      wb_sel,
  output logic [2:0]      imm_sel,
  output logic [2:0]      branch_type,
  output logic            retire,
  output logic            fault,
  output logic [2:0]      state
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam int                 c_CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(MEM_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    w_pc_nxt;
  logic [31:0]        r_instr;
  logic               w_instr_ld;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [c_CNT_W-1:0] w_wait_nxt;
  logic               r_fault;
  logic               w_imem_req;
  logic               w_dmem_req;
  logic               w_reg_wen;
  logic               w_retire;

  // Instruction fields and opcode class
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic            w_f7b5;
  logic            w_is_r, w_is_i, w_is_load, w_is_store;
  logic            w_is_branch, w_is_jal, w_is_lui, w_legal;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_tgt_misaligned;
  logic            w_wait_expired;
  logic            w_dec_valid;

  assign w_op        = r_instr[6:0];
  assign w_f3        = r_instr[14:12];
  assign w_f7b5      = r_instr[30];
  assign w_is_r      = (w_op == c_OP_R);
  assign w_is_i      = (w_op == c_OP_I);
  assign w_is_load   = (w_op == c_OP_LOAD);
  assign w_is_store  = (w_op == c_OP_STORE);
  assign w_is_branch = (w_op == c_OP_BRANCH);
  assign w_is_jal    = (w_op == c_OP_JAL);
  assign w_is_lui    = (w_op == c_OP_LUI);
  assign w_legal     = w_is_r | w_is_i | w_is_load | w_is_store |
                       w_is_branch | w_is_jal | w_is_lui;

  // Wraps naturally at XLEN bits
  assign w_pc_plus4       = r_pc + XLEN'(4);
  assign w_tgt_misaligned = (pc_target[1:0] != 2'b00);
  assign w_wait_expired   = (r_wait_cnt == c_TIMEOUT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_instr_ld) begin
        r_instr <= imem_rdata;
      end
      if (w_state_nxt == S_TRAP) begin
        r_fault <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and sequencing outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_ld  = 1'b0;
    w_wait_nxt  = '0;          // any state exit clears the wait counter
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_reg_wen   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        // A ready arriving on the expiry cycle still completes the fetch
        if (imem_ready) begin
          w_instr_ld  = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_wait_expired) begin
          w_state_nxt = S_TRAP;
        end else begin
          w_wait_nxt = r_wait_cnt + c_CNT_ONE;
        end
      end
      S_DECODE: begin
        w_state_nxt = w_legal ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        if (w_is_branch) begin
          if (br_taken && w_tgt_misaligned) begin
            w_state_nxt = S_TRAP;
          end else begin
            w_pc_nxt    = br_taken ? pc_target : w_pc_plus4;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = S_MEM;
        end else if (w_is_jal && w_tgt_misaligned) begin
          // Trap here so a bad JAL never reaches the register write
          w_state_nxt = S_TRAP;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        if (dmem_ready) begin
          if (w_is_store) begin
            w_pc_nxt    = w_pc_plus4;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_wait_expired) begin
          w_state_nxt = S_TRAP;
        end else begin
          w_wait_nxt = r_wait_cnt + c_CNT_ONE;
        end
      end
      S_WB: begin
        w_reg_wen   = 1'b1;
        w_pc_nxt    = w_is_jal ? pc_target : w_pc_plus4;
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_TRAP;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Decode outputs, held from DECODE through WRITEBACK
  // --------------------------------------------------------------------------
  assign w_dec_valid = (r_state == S_DECODE) || (r_state == S_EXECUTE) ||
                       (r_state == S_MEM)    || (r_state == S_WB);

  always_comb begin
    alu_sel     = 4'b0000;
    bsel        = 1'b0;
    wb_sel      = 2'b00;
    imm_sel     = 3'b000;
    branch_type = 3'b000;
    if (w_dec_valid) begin
      branch_type = 3'b010;
      case (w_op)
        c_OP_R: begin
          alu_sel = {w_f7b5, w_f3};
        end
        c_OP_I: begin
          // Only the shift-right encoding uses funct7[5] (SRLI vs SRAI)
          alu_sel = {(w_f3 == 3'b101) & w_f7b5, w_f3};
          bsel    = 1'b1;
        end
        c_OP_LOAD: begin
          bsel   = 1'b1;
          wb_sel = 2'b01;
        end
        c_OP_STORE: begin
          bsel    = 1'b1;
          imm_sel = 3'b001;
        end
        c_OP_BRANCH: begin
          imm_sel     = 3'b010;
          branch_type = w_f3;
        end
        c_OP_JAL: begin
          bsel    = 1'b1;
          wb_sel  = 2'b10;
          imm_sel = 3'b100;
        end
        c_OP_LUI: begin
          alu_sel = 4'b1111;
          bsel    = 1'b1;
          imm_sel = 3'b011;
        end
        default: begin
          branch_type = 3'b010;
        end
      endcase
    end
  end

  // The reset term drops a fetch request the moment reset asserts, since the
  // FSM itself sits in FETCH throughout reset.
  assign imem_req  = w_imem_req & ~reset;
  assign imem_addr = r_pc;
  assign dmem_req  = w_dmem_req;
  assign dmem_we   = w_dmem_req & w_is_store;
  assign reg_wen   = w_reg_wen;
  assign retire    = w_retire;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign fault     = r_fault;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_core_ctrl
// Purpose  : Testbench for mc_core_ctrl. Directed scenarios for reset,
//            latency, branches, traps, timeout and async reset, followed by a
//            randomized instruction stream checked by a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_core_ctrl;

  localparam int TMO   = 4;
  localparam int N_RND = 200;

  localparam logic [31:0] c_ADDI = 32'h00500093;
  localparam logic [31:0] c_LW   = 32'h00002083;
  localparam logic [31:0] c_BEQ  = 32'h00000063;
  localparam logic [31:0] c_BNE  = 32'h00001063;
  localparam logic [31:0] c_JAL  = 32'h0000006F;
  localparam logic [31:0] c_ILL  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, br_taken;
  logic [31:0] imem_addr, imem_rdata, pc_target, pc, instr;
  logic        reg_wen, bsel, retire, fault;
  logic [3:0]  alu_sel;
  logic [1:0]  wb_sel;
  logic [2:0]  imm_sel, branch_type, state;

  always #5 clk = ~clk;

  mc_core_ctrl #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .br_taken(br_taken), .pc_target(pc_target),
    .pc(pc), .instr(instr), .reg_wen(reg_wen), .alu_sel(alu_sel), .bsel(bsel),
    .wb_sel(wb_sel), .imm_sel(imm_sel), .branch_type(branch_type),
    .retire(retire), .fault(fault), .state(state)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: expected behaviour of one instruction
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [12:0] dec;   // {alu_sel, bsel, wb_sel, imm_sel, branch_type}
    logic        mem;
    logic        we;
    logic        wb;
  } exp_t;

  function automatic exp_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic tk, input logic [31:0] tgt);
    exp_t       e;
    logic [3:0] alu = 4'd0;
    logic       bs = 1'b0;
    logic [1:0] ws = 2'd0;
    logic [2:0] im = 3'd0;
    logic [2:0] bt = 3'b010;
    logic [2:0] f3 = ins[14:12];
    e.pc  = p;
    e.nxt = p + 32'd4;
    e.mem = 1'b0;
    e.we  = 1'b0;
    e.wb  = 1'b0;
    case (ins[6:0])
      7'b0110011: begin alu = {ins[30], f3}; e.wb = 1'b1; end
      7'b0010011: begin
        alu = {(f3 == 3'b101) ? ins[30] : 1'b0, f3}; bs = 1'b1; e.wb = 1'b1;
      end
      7'b0000011: begin bs = 1'b1; ws = 2'd1; e.mem = 1'b1; e.wb = 1'b1; end
      7'b0100011: begin bs = 1'b1; im = 3'd1; e.mem = 1'b1; e.we = 1'b1; end
      7'b1100011: begin im = 3'd2; bt = f3; if (tk) e.nxt = tgt; end
      7'b1101111: begin bs = 1'b1; ws = 2'd2; im = 3'd4; e.wb = 1'b1; e.nxt = tgt; end
      7'b0110111: begin alu = 4'hF; bs = 1'b1; im = 3'd3; e.wb = 1'b1; end
      default: ;
    endcase
    e.dec = {alu, bs, ws, im, bt};
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard monitor (random phase)
  // --------------------------------------------------------------------------
  exp_t        q[$];
  exp_t        cur;
  bit          mon_en = 1'b0;
  bit          have_cur = 1'b0;
  bit          mem_seen, wen_seen, pend = 1'b0;
  logic [31:0] pend_pc;
  int          n_ret = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        chk("pc_after_retire", pc, pend_pc);
        pend = 1'b0;
      end
      if (imem_req && imem_ready) begin
        chk("fetch_queue_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          mem_seen = 1'b0;
          wen_seen = 1'b0;
          chk("fetch_addr", imem_addr, cur.pc);
        end
      end
      if (have_cur && state == 3'd2)
        chk("decode_fields", {19'd0, alu_sel, bsel, wb_sel, imm_sel, branch_type},
            {19'd0, cur.dec});
      if (have_cur && dmem_req && dmem_ready) begin
        mem_seen = 1'b1;
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
      end
      if (have_cur && reg_wen) begin
        wen_seen = 1'b1;
        chk("wb_sel_at_wen", {30'd0, wb_sel}, {30'd0, cur.dec[7:6]});
      end
      if (retire) begin
        n_ret++;
        chk("retire_mem_wb", {30'd0, mem_seen, wen_seen}, {30'd0, cur.mem, cur.wb});
        pend     = 1'b1;
        pend_pc  = cur.nxt;
        have_cur = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  int          g_cyc, g_wen, g_ret, g_dreq;
  logic [31:0] g_seq;
  logic [3:0]  g_alu;
  logic        g_bsel, g_we;
  logic [1:0]  g_wbs;
  logic [2:0]  g_bt;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge in FETCH; runs one instruction with the given memory
  // latency until the core is back in FETCH or in TRAP.
  task automatic exec_one(input logic [31:0] ins, input int ddly,
                          input logic tk, input logic [31:0] tgt);
    int dcnt = 0;
    g_cyc = 0; g_wen = 0; g_ret = 0; g_dreq = 0; g_seq = '0;
    g_alu = '0; g_bsel = 1'b0; g_we = 1'b0; g_wbs = '0; g_bt = '0;
    imem_rdata = ins; imem_ready = 1'b1; br_taken = tk; pc_target = tgt;
    for (int k = 0; k < 20; k++) begin
      dmem_ready = (state == 3'd3) && (dcnt == ddly);
      #1;
      g_seq = {g_seq[27:0], 1'b0, state};
      g_cyc++;
      if (reg_wen) begin g_wen++; g_wbs = wb_sel; end
      if (retire) g_ret++;
      if (dmem_req) begin g_dreq++; dcnt++; g_we = dmem_we; end
      if (state == 3'd2) begin g_alu = alu_sel; g_bsel = bsel; g_bt = branch_type; end
      @(negedge clk);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (state == 3'd0 || state == 3'd7) break;
    end
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  logic [6:0]  ops [0:6];
  logic [31:0] model_pc, r, ins, tgt;
  logic        tk, ctl;
  exp_t        e;
  int          d, k, cnt;

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b0110111;
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
    br_taken = 1'b0; pc_target = '0;

    // T1: reset values, then ADDI with zero-wait fetch
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_outs", {20'd0, imem_req, dmem_req, reg_wen, retire, fault, alu_sel, bsel, branch_type},
        32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t1_imem_req", {31'd0, imem_req}, 32'd1);
    exec_one(c_ADDI, 0, 1'b0, 32'h0);
    chk("t1_states", g_seq, 32'h0124);
    chk("t1_wen_ret", {g_wen[15:0], g_ret[15:0]}, {16'd1, 16'd1});
    chk("t1_alu_bsel", {27'd0, g_alu, g_bsel}, 32'd1);
    chk("t1_pc", pc, 32'd4);
    chk("t1_instr", instr, c_ADDI);

    // T2: LW with dmem_ready three cycles late
    exec_one(c_LW, 3, 1'b0, 32'h0);
    chk("t2_dreq_cycles", g_dreq, 32'd4);
    chk("t2_we_wbsel", {29'd0, g_we, g_wbs}, 32'd1);
    chk("t2_cycles", g_cyc, 32'd8);
    chk("t2_states", g_seq, 32'h01233334);
    chk("t2_pc", pc, 32'd8);

    // T3: taken BEQ, then not-taken BNE with a misaligned (ignored) target
    exec_one(c_BEQ, 0, 1'b1, 32'h40);
    chk("t3_beq_states", g_seq, 32'h012);
    chk("t3_beq_wen_ret", {g_wen[15:0], g_ret[15:0]}, {16'd0, 16'd1});
    chk("t3_beq_pc", pc, 32'h40);
    exec_one(c_BNE, 0, 1'b0, 32'h41);
    chk("t3_bne_pc", pc, 32'h44);
    chk("t3_bne_bt_state", {26'd0, g_bt, state}, {26'd0, 3'd1, 3'd0});

    // Misaligned JAL target traps with pc unchanged
    exec_one(c_JAL, 0, 1'b0, 32'h42);
    chk("jal_mis_state", {29'd0, state}, 32'd7);
    chk("jal_mis_ret_wen", {g_ret[15:0], g_wen[15:0]}, 32'd0);
    chk("jal_mis_pc", pc, 32'h44);

    // T4: illegal opcode, sticky fault, no requests until reset
    do_reset();
    exec_one(c_ILL, 0, 1'b0, 32'h0);
    chk("t4_states", g_seq, 32'h01);
    chk("t4_state_fault", {28'd0, state, fault}, {28'd0, 3'd7, 1'b1});
    cnt = 0;
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (imem_req || !fault || state != 3'd7) cnt++;
    end
    imem_ready = 1'b0;
    chk("t4_trap_hold", cnt, 32'd0);
    do_reset();
    #1;
    chk("t4_after_rst", {pc[27:0], state, fault}, 32'd0);

    // T5: fetch timeout, and ready on the expiry cycle
    do_reset();
    g_seq = '0;
    for (int i = 0; i < 6; i++) begin
      #1; g_seq = {g_seq[27:0], 1'b0, state};
      @(negedge clk);
    end
    chk("t5_timeout_states", g_seq, 32'h000007);
    do_reset();
    repeat (4) @(negedge clk);
    imem_rdata = c_ADDI; imem_ready = 1'b1;
    #1;
    chk("t5_last_wait_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("t5_ready_wins", {28'd0, state, fault}, {28'd0, 3'd1, 1'b0});

    // Data-side timeout
    do_reset();
    exec_one(c_LW, 10, 1'b0, 32'h0);
    chk("dmem_timeout", {g_dreq[15:0], 13'd0, state}, {16'd5, 13'd0, 3'd7});

    // T6: async reset during MEM
    do_reset();
    imem_rdata = c_LW; imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      if (state == 3'd3) break;
    end
    #1;
    chk("t6_in_mem", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_abort", {26'd0, dmem_req, retire, state, fault}, 32'd0);
    chk("t6_pc", pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Random phase
    do_reset();
    q.delete();
    model_pc = 32'h0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < N_RND; n++) begin
      d = $urandom_range(0, 3);
      repeat (d) begin @(posedge clk); #1; end
      r   = $urandom;
      ins = {r[31:7], ops[$urandom_range(0, 6)]};
      tk  = 1'($urandom_range(0, 1));
      ctl = (ins[6:0] == 7'b1101111) || (ins[6:0] == 7'b1100011 && tk);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      if (ctl) tgt[1:0] = 2'b00;
      imem_rdata = ins; br_taken = tk; pc_target = tgt; imem_ready = 1'b1;
      e = model(model_pc, ins, tk, tgt);
      q.push_back(e);
      model_pc = e.nxt;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      if (e.mem) begin
        k = 0;
        while (!dmem_req && k < 10) begin @(posedge clk); #1; k++; end
        d = $urandom_range(0, 3);
        repeat (d) begin @(posedge clk); #1; end
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
      end
      k = 0;
      while (state != 3'd0 && k < 10) begin @(posedge clk); #1; k++; end
      chk("rnd_back_to_fetch", {29'd0, state}, 32'd0);
      if (state != 3'd0) break;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("rnd_retire_count", n_ret, N_RND);
    chk("rnd_queue_empty", q.size(), 32'd0);
    chk("rnd_no_fault", {31'd0, fault}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
